// File: rtl/RgbdVoConfigPk.sv
// -----------------------------------------------------------------------------
// RgbdVoConfigPk
// Shared configuration for the RGB-D VO datapath blocks.
//   - Default depth window and geometry pipeline latency.
//   - corr_side_t: sideband that travels next to a geometry request so it can
//     be re-joined with the geometry result (valid, frame markers, source
//     pixel coordinates and depth).
// No ports (package).
// -----------------------------------------------------------------------------
package RgbdVoConfigPk;

    localparam int CFG_H_BW      = 10;
    localparam int CFG_V_BW      = 10;
    localparam int CFG_DEPTH_BW  = 16;

    localparam int DEPTH_MIN_DEF = 1;
    localparam int DEPTH_MAX_DEF = 19999;
    localparam int GEO_PIPE_LAT  = 11;

    typedef struct packed {
        logic                    valid;
        logic                    fs;
        logic                    fe;
        logic [CFG_H_BW-1:0]     x;
        logic [CFG_V_BW-1:0]     y;
        logic [CFG_DEPTH_BW-1:0] depth;
    } corr_side_t;

endpackage

// File: rtl/corr_side_delay.sv
// -----------------------------------------------------------------------------
// corr_side_delay
// Fixed-length shift register for the correspondence sideband. Every stage
// shifts every cycle, so an entry written at cycle t appears on o_side at
// cycle t+PIPE_LAT.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset, clears every stage
//   i_side  sideband entering the line
//   o_side  sideband leaving the last stage
// -----------------------------------------------------------------------------
module corr_side_delay
    import RgbdVoConfigPk::*;
#(
    parameter int PIPE_LAT = GEO_PIPE_LAT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  corr_side_t i_side,
    output corr_side_t o_side
);

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
            corr_side_t stage_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        stage_q <= '0;
                    end else begin
                        stage_q <= i_side;
                    end
                end
            end else begin : g_body
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        stage_q <= '0;
                    end else begin
                        stage_q <= g_stage[gi-1].stage_q;
                    end
                end
            end
        end
    endgenerate

    assign o_side = g_stage[PIPE_LAT-1].stage_q;

endmodule

// File: rtl/corr_calc_ctrl.sv
// -----------------------------------------------------------------------------
// corr_calc_ctrl
// Frame-level control shell for direct correspondence calculation.
//   - Tracks pixel coordinates (with optional subsampling) and issues a
//     geometry request for every selected pixel whose depth is in the window.
//   - Delays the request sideband by PIPE_LAT so it lines up with the
//     external geometry result, bounds-checks the projected index, and
//     reports per-frame in-bound / out-of-bound counts.
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_frame_start/end, i_valid  input pixel stream markers and valid
//   i_depth0                    depth of the current pixel
//   r_hsize, r_vsize            frame size
//   r_depth_min/max             inclusive depth window
//   r_stride                    subsample step (0 behaves as 1)
//   o_geo_*                     request to the geometry pipeline
//   i_geo_*                     geometry result (signed projected index)
//   o_frame_start/end, o_valid  aligned output stream
//   o_depth0, o_idx0_*          source pixel depth and coordinates
//   o_idx1_*                    projected coordinates (0 unless o_valid)
//   o_corr_cnt, o_oob_cnt       counts for the last completed frame
//   o_cnt_valid                 one-cycle pulse when the counts update
//   o_lat_err                   sticky request/result valid mismatch
// -----------------------------------------------------------------------------
module corr_calc_ctrl
    import RgbdVoConfigPk::*;
#(
    parameter int H_BW      = CFG_H_BW,
    parameter int V_BW      = CFG_V_BW,
    parameter int DEPTH_BW  = CFG_DEPTH_BW,
    parameter int PROJ_BW   = 12,
    parameter int PIPE_LAT  = GEO_PIPE_LAT,
    parameter int STRIDE_BW = 3,
    parameter int CNT_BW    = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_frame_start,
    input  logic                 i_frame_end,
    input  logic                 i_valid,
    input  logic [DEPTH_BW-1:0]  i_depth0,
    input  logic [H_BW-1:0]      r_hsize,
    input  logic [V_BW-1:0]      r_vsize,
    input  logic [DEPTH_BW-1:0]  r_depth_min,
    input  logic [DEPTH_BW-1:0]  r_depth_max,
    input  logic [STRIDE_BW-1:0] r_stride,
    output logic                 o_geo_valid,
    output logic [H_BW-1:0]      o_geo_idx_x,
    output logic [V_BW-1:0]      o_geo_idx_y,
    output logic [DEPTH_BW-1:0]  o_geo_depth,
    input  logic                 i_geo_valid,
    input  logic [PROJ_BW-1:0]   i_geo_idx_x,
    input  logic [PROJ_BW-1:0]   i_geo_idx_y,
    output logic                 o_frame_start,
    output logic                 o_frame_end,
    output logic                 o_valid,
    output logic [DEPTH_BW-1:0]  o_depth0,
    output logic [H_BW-1:0]      o_idx0_x,
    output logic [V_BW-1:0]      o_idx0_y,
    output logic [H_BW-1:0]      o_idx1_x,
    output logic [V_BW-1:0]      o_idx1_y,
    output logic [CNT_BW-1:0]    o_corr_cnt,
    output logic [CNT_BW-1:0]    o_oob_cnt,
    output logic                 o_cnt_valid,
    output logic                 o_lat_err
);

    // One extra bit so the projected index and the frame size compare as
    // non-negative numbers of equal width.
    localparam int CWX = ((PROJ_BW > H_BW) ? PROJ_BW : H_BW) + 1;
    localparam int CWY = ((PROJ_BW > V_BW) ? PROJ_BW : V_BW) + 1;

    // ---------------------------------------------------------------------
    // Pixel coordinate and stride phase tracking
    // ---------------------------------------------------------------------
    logic [H_BW-1:0]      x_q, x_d, cur_x;
    logic [V_BW-1:0]      y_q, y_d, cur_y;
    logic [STRIDE_BW-1:0] sx_q, sx_d, cur_sx;
    logic [STRIDE_BW-1:0] sy_q, sy_d, cur_sy;
    logic [STRIDE_BW-1:0] stride_m1;
    logic                 selected;
    logic                 depth_ok;

    assign stride_m1 = (r_stride == '0) ? '0 : r_stride - STRIDE_BW'(1);

    // frame_start overrides whatever position the counters drifted to.
    assign cur_x  = i_frame_start ? '0 : x_q;
    assign cur_y  = i_frame_start ? '0 : y_q;
    assign cur_sx = i_frame_start ? '0 : sx_q;
    assign cur_sy = i_frame_start ? '0 : sy_q;

    assign selected = (cur_sx == '0) && (cur_sy == '0);
    assign depth_ok = (i_depth0 >= r_depth_min) && (i_depth0 <= r_depth_max);

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        sx_d = sx_q;
        sy_d = sy_q;
        if (i_valid) begin
            if (cur_x == r_hsize - H_BW'(1)) begin
                x_d  = '0;
                sx_d = '0;
                if (cur_y == r_vsize - V_BW'(1)) begin
                    y_d  = '0;
                    sy_d = '0;
                end else begin
                    y_d  = cur_y + V_BW'(1);
                    sy_d = (cur_sy == stride_m1) ? '0 : cur_sy + STRIDE_BW'(1);
                end
            end else begin
                x_d  = cur_x + H_BW'(1);
                sx_d = (cur_sx == stride_m1) ? '0 : cur_sx + STRIDE_BW'(1);
                y_d  = cur_y;
                sy_d = cur_sy;
            end
        end else if (i_frame_start) begin
            // Marker without a pixel: the next valid pixel is (0,0).
            x_d  = '0;
            y_d  = '0;
            sx_d = '0;
            sy_d = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Geometry request registers
    // ---------------------------------------------------------------------
    logic                geo_valid_q;
    logic [H_BW-1:0]     geo_x_q;
    logic [V_BW-1:0]     geo_y_q;
    logic [DEPTH_BW-1:0] geo_depth_q;
    logic                req_fs_q;
    logic                req_fe_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q         <= '0;
            y_q         <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            geo_valid_q <= 1'b0;
            geo_x_q     <= '0;
            geo_y_q     <= '0;
            geo_depth_q <= '0;
            req_fs_q    <= 1'b0;
            req_fe_q    <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            geo_valid_q <= i_valid & selected & depth_ok;
            req_fs_q    <= i_frame_start;
            req_fe_q    <= i_frame_end;
            // Fields follow every valid pixel, rejected ones included, so the
            // sideband always carries the most recent source pixel.
            if (i_valid) begin
                geo_x_q     <= cur_x;
                geo_y_q     <= cur_y;
                geo_depth_q <= i_depth0;
            end
        end
    end

    assign o_geo_valid = geo_valid_q;
    assign o_geo_idx_x = geo_x_q;
    assign o_geo_idx_y = geo_y_q;
    assign o_geo_depth = geo_depth_q;

    // ---------------------------------------------------------------------
    // Sideband delay line: tap lines up with i_geo_* of the same request
    // ---------------------------------------------------------------------
    corr_side_t side_in;
    corr_side_t tap;

    always_comb begin
        side_in       = '0;
        side_in.valid = geo_valid_q;
        side_in.fs    = req_fs_q;
        side_in.fe    = req_fe_q;
        side_in.x     = geo_x_q;
        side_in.y     = geo_y_q;
        side_in.depth = geo_depth_q;
    end

    corr_side_delay #(
        .PIPE_LAT (PIPE_LAT)
    ) u_side_delay (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_side (side_in),
        .o_side (tap)
    );

    // ---------------------------------------------------------------------
    // Bounds check, counters, latency check
    // ---------------------------------------------------------------------
    logic [CWX-1:0]    gx_ext;
    logic [CWY-1:0]    gy_ext;
    logic              in_bound;
    logic              hit;
    logic              miss;
    logic [CNT_BW-1:0] corr_base, corr_new, corr_run_q, corr_run_d;
    logic [CNT_BW-1:0] oob_base, oob_new, oob_run_q, oob_run_d;
    logic              lat_err_q, lat_err_d;

    assign gx_ext = CWX'(i_geo_idx_x);
    assign gy_ext = CWY'(i_geo_idx_y);

    // Sign bit clear means non-negative; then an unsigned compare suffices.
    assign in_bound = ~i_geo_idx_x[PROJ_BW-1] && (gx_ext < CWX'(r_hsize)) &&
                      ~i_geo_idx_y[PROJ_BW-1] && (gy_ext < CWY'(r_vsize));
    assign hit  = i_geo_valid & in_bound;
    assign miss = i_geo_valid & ~in_bound;

    always_comb begin
        // The frame_start result belongs to the new frame, so clear first.
        corr_base  = tap.fs ? '0 : corr_run_q;
        oob_base   = tap.fs ? '0 : oob_run_q;
        corr_new   = (hit  && (corr_base != '1)) ? corr_base + CNT_BW'(1) : corr_base;
        oob_new    = (miss && (oob_base  != '1)) ? oob_base  + CNT_BW'(1) : oob_base;
        corr_run_d = tap.fe ? '0 : corr_new;
        oob_run_d  = tap.fe ? '0 : oob_new;
        // A mismatch on the frame_start cycle itself still counts.
        lat_err_d  = (tap.fs ? 1'b0 : lat_err_q) | (i_geo_valid ^ tap.valid);
    end

    logic                valid_q;
    logic [H_BW-1:0]     idx1_x_q;
    logic [V_BW-1:0]     idx1_y_q;
    logic [H_BW-1:0]     idx0_x_q;
    logic [V_BW-1:0]     idx0_y_q;
    logic [DEPTH_BW-1:0] depth0_q;
    logic                fs_out_q;
    logic                fe_out_q;
    logic [CNT_BW-1:0]   corr_cnt_q;
    logic [CNT_BW-1:0]   oob_cnt_q;
    logic                cnt_valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            idx1_x_q    <= '0;
            idx1_y_q    <= '0;
            idx0_x_q    <= '0;
            idx0_y_q    <= '0;
            depth0_q    <= '0;
            fs_out_q    <= 1'b0;
            fe_out_q    <= 1'b0;
            corr_run_q  <= '0;
            oob_run_q   <= '0;
            corr_cnt_q  <= '0;
            oob_cnt_q   <= '0;
            cnt_valid_q <= 1'b0;
            lat_err_q   <= 1'b0;
        end else begin
            valid_q     <= hit;
            idx1_x_q    <= hit ? H_BW'(i_geo_idx_x) : '0;
            idx1_y_q    <= hit ? V_BW'(i_geo_idx_y) : '0;
            idx0_x_q    <= tap.x;
            idx0_y_q    <= tap.y;
            depth0_q    <= tap.depth;
            fs_out_q    <= tap.fs;
            fe_out_q    <= tap.fe;
            corr_run_q  <= corr_run_d;
            oob_run_q   <= oob_run_d;
            cnt_valid_q <= tap.fe;
            lat_err_q   <= lat_err_d;
            if (tap.fe) begin
                corr_cnt_q <= corr_new;
                oob_cnt_q  <= oob_new;
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_idx1_x      = idx1_x_q;
    assign o_idx1_y      = idx1_y_q;
    assign o_idx0_x      = idx0_x_q;
    assign o_idx0_y      = idx0_y_q;
    assign o_depth0      = depth0_q;
    assign o_frame_start = fs_out_q;
    assign o_frame_end   = fe_out_q;
    assign o_corr_cnt    = corr_cnt_q;
    assign o_oob_cnt     = oob_cnt_q;
    assign o_cnt_valid   = cnt_valid_q;
    assign o_lat_err     = lat_err_q;

endmodule

// File: tb/tb_corr_calc_ctrl.sv
module tb_corr_calc_ctrl;

    localparam int LAT  = 11;
    localparam int DMIN = 1;
    localparam int DMAX = 19999;

    logic        clk;
    logic        rst;
    logic        i_frame_start, i_frame_end, i_valid;
    logic [15:0] i_depth0;
    logic [9:0]  r_hsize, r_vsize;
    logic [15:0] r_depth_min, r_depth_max;
    logic [2:0]  r_stride;
    logic        o_geo_valid;
    logic [9:0]  o_geo_idx_x, o_geo_idx_y;
    logic [15:0] o_geo_depth;
    logic        i_geo_valid;
    logic [11:0] i_geo_idx_x, i_geo_idx_y;
    logic        o_frame_start, o_frame_end, o_valid;
    logic [15:0] o_depth0;
    logic [9:0]  o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y;
    logic [19:0] o_corr_cnt, o_oob_cnt;
    logic        o_cnt_valid, o_lat_err;

    corr_calc_ctrl #(
        .H_BW(10), .V_BW(10), .DEPTH_BW(16), .PROJ_BW(12),
        .PIPE_LAT(LAT), .STRIDE_BW(3), .CNT_BW(20)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_valid(i_valid), .i_depth0(i_depth0),
        .r_hsize(r_hsize), .r_vsize(r_vsize),
        .r_depth_min(r_depth_min), .r_depth_max(r_depth_max),
        .r_stride(r_stride),
        .o_geo_valid(o_geo_valid), .o_geo_idx_x(o_geo_idx_x),
        .o_geo_idx_y(o_geo_idx_y), .o_geo_depth(o_geo_depth),
        .i_geo_valid(i_geo_valid), .i_geo_idx_x(i_geo_idx_x),
        .i_geo_idx_y(i_geo_idx_y),
        .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
        .o_valid(o_valid), .o_depth0(o_depth0),
        .o_idx0_x(o_idx0_x), .o_idx0_y(o_idx0_y),
        .o_idx1_x(o_idx1_x), .o_idx1_y(o_idx1_y),
        .o_corr_cnt(o_corr_cnt), .o_oob_cnt(o_oob_cnt),
        .o_cnt_valid(o_cnt_valid), .o_lat_err(o_lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Geometry pipeline model: returns the request index plus proj_off,
    // LAT cycles after the request (LAT+1 when late_n is 1).
    int          proj_off;
    int          late_n;
    logic        mv [0:LAT];
    logic [11:0] mx [0:LAT];
    logic [11:0] my [0:LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= LAT; k++) begin
                mv[k] <= 1'b0;
                mx[k] <= 12'd0;
                my[k] <= 12'd0;
            end
        end else begin
            mv[0] <= o_geo_valid;
            mx[0] <= 12'(o_geo_idx_x) + 12'(proj_off);
            my[0] <= 12'(o_geo_idx_y) + 12'(proj_off);
            for (int k = 1; k <= LAT; k++) begin
                mv[k] <= mv[k-1];
                mx[k] <= mx[k-1];
                my[k] <= my[k-1];
            end
        end
    end

    assign i_geo_valid = mv[LAT-1+late_n];
    assign i_geo_idx_x = mx[LAT-1+late_n];
    assign i_geo_idx_y = my[LAT-1+late_n];

    int pulse_total = 0;
    always @(negedge clk) begin
        if (o_cnt_valid) pulse_total <= pulse_total + 1;
    end

    typedef struct packed {
        logic        fs;
        logic        fe;
        logic [15:0] depth;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        e_gv;
        logic        e_valid;
        logic [9:0]  e_x1;
        logic [9:0]  e_y1;
    } vec_t;

    vec_t vecs [0:63];
    int   nvec;
    int   dep_tab [0:63];
    int   exp_corr, exp_oob;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic fill_depth(input int d);
        for (int k = 0; k < 64; k++) dep_tab[k] = d;
    endtask

    // Appends one frame of records together with their expected results.
    task automatic build_frame(input int hs, input int vs, input int st, input int off);
        vec_t v;
        int   d, px, py;
        bit   gv, inb;
        exp_corr = 0;
        exp_oob  = 0;
        for (int y = 0; y < vs; y++) begin
            for (int x = 0; x < hs; x++) begin
                d   = dep_tab[y*hs + x];
                gv  = ((x % st) == 0) && ((y % st) == 0) && (d >= DMIN) && (d <= DMAX);
                px  = x + off;
                py  = y + off;
                inb = (px < hs) && (py < vs);
                v.fs      = (x == 0) && (y == 0);
                v.fe      = (x == hs-1) && (y == vs-1);
                v.depth   = 16'(d);
                v.x       = 10'(x);
                v.y       = 10'(y);
                v.e_gv    = gv;
                v.e_valid = gv && inb;
                v.e_x1    = (gv && inb) ? 10'(px) : 10'd0;
                v.e_y1    = (gv && inb) ? 10'(py) : 10'd0;
                if (gv && inb) exp_corr++;
                if (gv && !inb) exp_oob++;
                vecs[nvec] = v;
                nvec++;
            end
        end
    endtask

    task automatic drive(input int i, input int n);
        if (i < n) begin
            i_valid       = 1'b1;
            i_frame_start = vecs[i].fs;
            i_frame_end   = vecs[i].fe;
            i_depth0      = vecs[i].depth;
        end else begin
            i_valid       = 1'b0;
            i_frame_start = 1'b0;
            i_frame_end   = 1'b0;
            i_depth0      = 16'd0;
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Streams vecs[0..n-1] back to back and checks requests one cycle later
    // and the aligned output LAT+2 cycles later.
    task automatic run_table(input int n, input bit chk_out, input bit lat_b, input bit lat_a);
        int j;
        for (int i = 0; i < n + LAT + 2; i++) begin
            if (chk_out && i >= 1 && i <= n) begin
                j = i - 1;
                chk("geo_valid", j, 32'(o_geo_valid), 32'(vecs[j].e_gv));
                chk("geo_x",     j, 32'(o_geo_idx_x), 32'(vecs[j].x));
                chk("geo_y",     j, 32'(o_geo_idx_y), 32'(vecs[j].y));
                chk("geo_depth", j, 32'(o_geo_depth), 32'(vecs[j].depth));
            end
            if (chk_out && i < LAT + 2) chk("no_early_valid", i, 32'(o_valid), 32'd0);
            if (i == LAT + 1) chk("lat_err_before", i, 32'(o_lat_err), 32'(lat_b));
            if (i == LAT + 2) chk("lat_err_after",  i, 32'(o_lat_err), 32'(lat_a));
            if (chk_out && i >= LAT + 2) begin
                j = i - LAT - 2;
                chk("o_valid",   j, 32'(o_valid),       32'(vecs[j].e_valid));
                chk("idx0_x",    j, 32'(o_idx0_x),      32'(vecs[j].x));
                chk("idx0_y",    j, 32'(o_idx0_y),      32'(vecs[j].y));
                chk("depth0",    j, 32'(o_depth0),      32'(vecs[j].depth));
                chk("idx1_x",    j, 32'(o_idx1_x),      32'(vecs[j].e_x1));
                chk("idx1_y",    j, 32'(o_idx1_y),      32'(vecs[j].e_y1));
                chk("o_fs",      j, 32'(o_frame_start), 32'(vecs[j].fs));
                chk("o_fe",      j, 32'(o_frame_end),   32'(vecs[j].fe));
                chk("cnt_valid", j, 32'(o_cnt_valid),   32'(vecs[j].fe));
            end
            drive(i, n);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input int tag);
        chk("rst_geo_valid", tag, 32'(o_geo_valid),   32'd0);
        chk("rst_geo_x",     tag, 32'(o_geo_idx_x),   32'd0);
        chk("rst_geo_depth", tag, 32'(o_geo_depth),   32'd0);
        chk("rst_valid",     tag, 32'(o_valid),       32'd0);
        chk("rst_idx0_x",    tag, 32'(o_idx0_x),      32'd0);
        chk("rst_idx1_x",    tag, 32'(o_idx1_x),      32'd0);
        chk("rst_depth0",    tag, 32'(o_depth0),      32'd0);
        chk("rst_fs",        tag, 32'(o_frame_start), 32'd0);
        chk("rst_fe",        tag, 32'(o_frame_end),   32'd0);
        chk("rst_corr",      tag, 32'(o_corr_cnt),    32'd0);
        chk("rst_oob",       tag, 32'(o_oob_cnt),     32'd0);
        chk("rst_cnt_valid", tag, 32'(o_cnt_valid),   32'd0);
        chk("rst_lat_err",   tag, 32'(o_lat_err),     32'd0);
    endtask

    task automatic check_counts(input int tag, input int pulses_before, input int frames);
        chk("corr_cnt", tag, 32'(o_corr_cnt), 32'(exp_corr));
        chk("oob_cnt",  tag, 32'(o_oob_cnt),  32'(exp_oob));
        chk("pulses",   tag, 32'(pulse_total - pulses_before), 32'(frames));
    endtask

    int p0;

    initial begin
        proj_off      = 0;
        late_n        = 0;
        rst           = 1'b1;
        i_frame_start = 1'b0;
        i_frame_end   = 1'b0;
        i_valid       = 1'b0;
        i_depth0      = 16'd0;
        r_hsize       = 10'd4;
        r_vsize       = 10'd3;
        r_depth_min   = 16'(DMIN);
        r_depth_max   = 16'(DMAX);
        r_stride      = 3'd1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero(0);
        rst = 1'b0;
        idle(2);

        // 1: 4x3, stride 1, projection +1 -> right column / bottom row out of bounds
        proj_off = 1;
        fill_depth(100);
        nvec = 0;
        build_frame(4, 3, 1, 1);
        p0 = pulse_total;
        run_table(nvec, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_counts(1, p0, 1);

        // 2: depth window edges on a 4x1 frame
        proj_off = 0;
        r_hsize  = 10'd4;
        r_vsize  = 10'd1;
        fill_depth(100);
        dep_tab[0] = 0;
        dep_tab[1] = 1;
        dep_tab[2] = 19999;
        dep_tab[3] = 20000;
        nvec = 0;
        build_frame(4, 1, 1, 0);
        p0 = pulse_total;
        run_table(nvec, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_counts(2, p0, 1);

        // 3: 8x4, stride 2, identity projection
        r_hsize  = 10'd8;
        r_vsize  = 10'd4;
        r_stride = 3'd2;
        fill_depth(100);
        nvec = 0;
        build_frame(8, 4, 2, 0);
        p0 = pulse_total;
        run_table(nvec, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_counts(3, p0, 1);

        // 4: geometry result one cycle late -> sticky lat_err until next frame_start
        r_hsize  = 10'd4;
        r_vsize  = 10'd3;
        r_stride = 3'd1;
        late_n   = 1;
        nvec = 0;
        build_frame(4, 3, 1, 0);
        run_table(nvec, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("lat_sticky", 0, 32'(o_lat_err), 32'd1);
        late_n = 0;
        idle(LAT + 3);
        chk("lat_sticky", 1, 32'(o_lat_err), 32'd1);
        p0 = pulse_total;
        run_table(nvec, 1'b1, 1'b1, 1'b0);
        idle(2);
        check_counts(4, p0, 1);

        // 5: reset mid-frame, then a clean frame (stride 0 behaves as 1)
        r_stride = 3'd0;
        for (int i = 0; i < 5; i++) begin
            drive(i, nvec);
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        drive(0, 0);
        #1;
        check_zero(1);
        @(posedge clk); #1;
        check_zero(2);
        rst = 1'b0;
        idle(1);
        p0 = pulse_total;
        run_table(nvec, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_counts(5, p0, 1);

        // 6: three back-to-back 1x1 frames with frame_start == frame_end
        r_hsize  = 10'd1;
        r_vsize  = 10'd1;
        r_stride = 3'd1;
        nvec = 0;
        build_frame(1, 1, 1, 0);
        build_frame(1, 1, 1, 0);
        build_frame(1, 1, 1, 0);
        p0 = pulse_total;
        run_table(nvec, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_counts(6, p0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
